ysyx_23060332_lsu: RTL and testbench
====================================

Name: ysyx_23060332_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Takes one memory request per transaction: address, store data, func3 size/sign code, read/write enables.
- Checks alignment and builds the byte strobe. Drives a valid/ready request/response memory bus.
- Returns sign- or zero-extended load data to writeback through a valid/ready handshake.
- Multi-cycle; one outstanding transaction; replaces single-cycle combinational memory access.

Parameters:
- ADDR_W, 32, address width; data width is fixed at 32.
- TIMEOUT, 256, maximum cycles in WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  LSU can accept a request
- req_ren  in  1  load request
- req_wen  in  1  store request
- req_addr  in  ADDR_W  effective address
- req_wdata  in  32  store data from rs2
- req_func3  in  3  load: LB=000 LH=001 LW=010 LBU=100 LHU=101; store: SB=000 SH=001 SW=010
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  ADDR_W  word-aligned address (req_addr with [1:0] cleared)
- bus_wen  out  1  1 = write, 0 = read
- bus_wdata  out  32  store data, lane-replicated
- bus_wstrb  out  4  byte strobe
- bus_resp_valid  in  1  bus response valid
- bus_resp_ready  out  1  LSU accepts response
- bus_rdata  in  32  read data (full word)
- bus_resp_err  in  1  bus error
- resp_valid  out  1  result valid to writeback
- resp_ready  in  1  writeback accepts result
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned, illegal func3, bus error, or timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE. req_ready=1. All other outputs 0. Timeout counter 0. Reset mid-transaction abandons it immediately; no further bus signalling.
- req_ready=1 only in IDLE. A request is accepted on a cycle T with req_valid&&req_ready. Address, func3, data and enables are captured in registers.
- Request decoding at acceptance:
  - req_ren&&req_wen both set, or illegal func3 for the operation: DONE with resp_err=1. No bus access.
  - Misaligned (LH/LHU/SH with addr[0]≠0; LW/SW with addr[1:0]≠0): DONE with err. No bus access.
  - Neither ren nor wen: DONE with err=0, rdata=0. No bus access.
  - Otherwise: REQ.
- REQ: bus_req_valid=1. bus_addr, bus_wen, bus_wdata, bus_wstrb stay stable until bus_req_ready. On handshake, go to WAIT.
- Store strobes and data:
  - SB: wstrb = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'hF.
  - Reads: wstrb = 0.
- WAIT: bus_resp_ready=1. On bus_resp_valid, go to DONE:
  - Loads: rdata = bus_rdata >> (8*addr[1:0]), then LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Stores: rdata = 0.
  - resp_err = bus_resp_err.
- Timeout: the counter increments each WAIT cycle. When it reaches TIMEOUT-1 with no response, go to DONE with err=1. Any later stray bus response is ignored while not in WAIT. The counter clears on WAIT entry.
- DONE: resp_valid=1 with rdata/err registered and stable until resp_ready. On handshake, go to IDLE. A new request can be accepted the cycle after.
- Latency with zero-wait bus: accept T, bus request handshake T+1, response T+2, resp_valid T+3. Local-error and no-op cases: resp_valid at T+1.
- Backpressure: resp_ready=0 holds DONE indefinitely. No new request is accepted.

Test Plan:
- SW addr=0x80000004 wdata=0x12345678, zero-wait bus → bus_wstrb=4'hF, bus_addr=0x80000004, resp_valid at T+3, rdata=0, err=0.
- LB addr=0x80000003, bus_rdata=0x80AABBCC → resp_rdata=0xFFFFFF80. Repeat as LBU → 0x00000080. LHU addr=…02 → 0x000080AA.
- SH addr=0x80000002 wdata=0x0000BEEF → bus_wstrb=4'b1100, bus_wdata=0xBEEFBEEF. bus_req_ready held low 3 cycles: signals remain stable.
- LW addr=0x80000001 → no bus_req_valid, resp_valid at T+1 with err=1. req_ren=req_wen=1 → same result.
- LW with bus never responding, TIMEOUT=8 → err=1 after 8 WAIT cycles. A stray bus response in the next IDLE is ignored.
- rst_n pulsed low during WAIT → all outputs 0 asynchronously, req_ready=1. resp_ready=0 for 5 cycles in DONE holds rdata and err stable.

Source files
------------

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: decodes one execute-stage memory request, runs it over a
// valid/ready request/response bus and returns extended load data to writeback.
module ysyx_23060332_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_func3,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_resp_valid,
    output logic              bus_resp_ready,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_resp_err,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [2:0]         r_func3;
    logic [31:0]        r_wdata;
    logic               r_wen;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_f3_ok;
    logic               w_misalign;
    logic               w_local_err;
    logic               w_go_bus;
    logic               w_timeout;
    logic               w_in_req;
    logic [3:0]         w_strb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shift;
    logic [31:0]        w_load;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_f3_ok = 1'b0;
        if (req_ren)
            w_f3_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                      (req_func3 == 3'b100) || (req_func3 == 3'b101);
        else if (req_wen)
            w_f3_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
    end

    // func3[1:0] encodes the access size for every legal load/store code
    always_comb begin
        w_misalign = 1'b0;
        case (req_func3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = (req_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_local_err = (req_ren && req_wen) || ((req_ren || req_wen) && (!w_f3_ok || w_misalign));
    assign w_go_bus    = (req_ren || req_wen) && !w_local_err;
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_go_bus ? S_REQ : S_DONE;
            S_REQ:  if (bus_req_ready) w_next = S_WAIT;
            S_WAIT: if (bus_resp_valid || w_timeout) w_next = S_DONE;
            S_DONE: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_func3 <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_func3 <= req_func3;
            r_wdata <= req_wdata;
            r_wen   <= req_wen;
            r_rdata <= '0;
            r_err   <= w_local_err;
        end else if (r_state == S_WAIT) begin
            if (bus_resp_valid) begin
                r_rdata <= r_wen ? 32'h0 : w_load;
                r_err   <= bus_resp_err;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    // Counter is held at zero outside WAIT so it starts fresh on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state != S_WAIT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    always_comb begin
        w_strb  = 4'hF;
        w_wdata = r_wdata;
        case (r_func3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_strb  = 4'hF;
                w_wdata = r_wdata;
            end
        endcase
    end

    assign w_shift = bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_func3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    assign w_in_req       = (r_state == S_REQ);
    assign req_ready      = (r_state == S_IDLE);
    assign bus_req_valid  = w_in_req;
    assign bus_addr       = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus_wen        = w_in_req && r_wen;
    assign bus_wdata      = (w_in_req && r_wen) ? w_wdata : 32'h0;
    assign bus_wstrb      = (w_in_req && r_wen) ? w_strb : 4'h0;
    assign bus_resp_ready = (r_state == S_WAIT);
    assign resp_valid     = (r_state == S_DONE);
    assign resp_rdata     = (r_state == S_DONE) ? r_rdata : 32'h0;
    assign resp_err       = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for the LSU: bus loads/stores, local errors, stalls,
// writeback backpressure, timeout and mid-transaction reset.
module tb_ysyx_23060332_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [31:0] bus_rdata;
    logic        bus_resp_err;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    ysyx_23060332_lsu #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_func3(req_func3),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_resp_valid(bus_resp_valid),
        .bus_resp_ready(bus_resp_ready), .bus_rdata(bus_rdata),
        .bus_resp_err(bus_resp_err), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic driveReq(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        req_valid = 1'b1;
        req_ren   = ren;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_func3 = f3;
        @(negedge clk);
        req_valid = 1'b0;
        req_ren   = 1'b0;
        req_wen   = 1'b0;
    endtask

    // Full bus transaction; stall delays bus_req_ready, hold delays resp_ready
    task automatic applyStimulus(input string tag, input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [31:0] brdata,
                                 input logic berr, input int stall, input int hold,
                                 input logic [31:0] eAddr, input logic eWen,
                                 input logic [3:0] eStrb, input logic [31:0] eWdata,
                                 input logic [31:0] eRdata, input logic eErr);
        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, req_ready, 1);
        driveReq(ren, wen, addr, wdata, f3);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput({tag, " bus_req_valid"}, bus_req_valid, 1);
            checkOutput({tag, " bus_addr"}, bus_addr, eAddr);
            checkOutput({tag, " bus_wen"}, bus_wen, eWen);
            checkOutput({tag, " bus_wstrb"}, bus_wstrb, eStrb);
            checkOutput({tag, " bus_wdata"}, bus_wdata, eWdata);
        end
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        checkOutput({tag, " bus_req_valid drop"}, bus_req_valid, 0);
        checkOutput({tag, " bus_resp_ready"}, bus_resp_ready, 1);
        bus_resp_valid = 1'b1;
        bus_rdata      = brdata;
        bus_resp_err   = berr;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'h0;
        bus_resp_err   = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput({tag, " resp_valid"}, resp_valid, 1);
            checkOutput({tag, " resp_rdata"}, resp_rdata, eRdata);
            checkOutput({tag, " resp_err"}, resp_err, eErr);
            checkOutput({tag, " req_ready busy"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, " resp_valid drop"}, resp_valid, 0);
        checkOutput({tag, " req_ready back"}, req_ready, 1);
    endtask

    task automatic applyLocalStimulus(input string tag, input logic ren, input logic wen,
                                      input logic [31:0] addr, input logic [2:0] f3,
                                      input logic eErr);
        @(negedge clk);
        driveReq(ren, wen, addr, 32'hCAFEF00D, f3);
        checkOutput({tag, " no bus_req_valid"}, bus_req_valid, 0);
        checkOutput({tag, " resp_valid"}, resp_valid, 1);
        checkOutput({tag, " resp_err"}, resp_err, eErr);
        checkOutput({tag, " resp_rdata"}, resp_rdata, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, " req_ready back"}, req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_func3 = 3'b000;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        bus_resp_err = 1'b0; resp_ready = 1'b0;
        #2;
        checkOutput("rst req_ready", req_ready, 1);
        checkOutput("rst bus_req_valid", bus_req_valid, 0);
        checkOutput("rst bus_resp_ready", bus_resp_ready, 0);
        checkOutput("rst resp_valid", resp_valid, 0);
        checkOutput("rst resp_rdata", resp_rdata, 0);
        checkOutput("rst bus_wstrb", bus_wstrb, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("sw", 0, 1, 32'h80000004, 32'h12345678, 3'b010, 32'h0, 0, 0, 0,
                      32'h80000004, 1, 4'hF, 32'h12345678, 32'h0, 0);
        applyStimulus("lb", 1, 0, 32'h80000003, 32'h0, 3'b000, 32'h80AABBCC, 0, 0, 5,
                      32'h80000000, 0, 4'h0, 32'h0, 32'hFFFFFF80, 0);
        applyStimulus("lbu", 1, 0, 32'h80000003, 32'h0, 3'b100, 32'h80AABBCC, 0, 0, 0,
                      32'h80000000, 0, 4'h0, 32'h0, 32'h00000080, 0);
        applyStimulus("lhu", 1, 0, 32'h80000002, 32'h0, 3'b101, 32'h80AABBCC, 0, 0, 0,
                      32'h80000000, 0, 4'h0, 32'h0, 32'h000080AA, 0);
        applyStimulus("lh", 1, 0, 32'h80000002, 32'h0, 3'b001, 32'h80AABBCC, 0, 0, 0,
                      32'h80000000, 0, 4'h0, 32'h0, 32'hFFFF80AA, 0);
        applyStimulus("lw berr", 1, 0, 32'h80000010, 32'h0, 3'b010, 32'h11223344, 1, 0, 0,
                      32'h80000010, 0, 4'h0, 32'h0, 32'h11223344, 1);
        applyStimulus("sh stall", 0, 1, 32'h80000002, 32'h0000BEEF, 3'b001, 32'h0, 0, 3, 0,
                      32'h80000000, 1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0);
        applyStimulus("sb", 0, 1, 32'h80000001, 32'h123456A5, 3'b000, 32'hFFFFFFFF, 0, 0, 0,
                      32'h80000000, 1, 4'b0010, 32'hA5A5A5A5, 32'h0, 0);

        applyLocalStimulus("lw misaligned", 1, 0, 32'h80000001, 3'b010, 1);
        applyLocalStimulus("ren+wen", 1, 1, 32'h80000000, 3'b010, 1);
        applyLocalStimulus("load f3=011", 1, 0, 32'h80000000, 3'b011, 1);
        applyLocalStimulus("store f3=100", 0, 1, 32'h80000000, 3'b100, 1);
        applyLocalStimulus("lh misaligned", 1, 0, 32'h80000003, 3'b001, 1);
        applyLocalStimulus("sh misaligned", 0, 1, 32'h80000001, 3'b001, 1);
        applyLocalStimulus("noop", 0, 0, 32'h80000000, 3'b010, 0);

        // Bus never answers: eight WAIT cycles, then an error response
        @(negedge clk);
        driveReq(1, 0, 32'h80000008, 32'h0, 3'b010);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("timeout wait bus_resp_ready", bus_resp_ready, 1);
            checkOutput("timeout wait resp_valid", resp_valid, 0);
            @(negedge clk);
        end
        checkOutput("timeout resp_valid", resp_valid, 1);
        checkOutput("timeout resp_err", resp_err, 1);
        checkOutput("timeout resp_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h55555555;
        bus_resp_err   = 1'b1;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'h0;
        bus_resp_err   = 1'b0;
        checkOutput("stray resp req_ready", req_ready, 1);
        checkOutput("stray resp resp_valid", resp_valid, 0);
        checkOutput("stray resp bus_resp_ready", bus_resp_ready, 0);

        // Reset asserted while waiting for the bus
        driveReq(1, 0, 32'h80000020, 32'h0, 3'b010);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        checkOutput("prereset bus_resp_ready", bus_resp_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst bus_resp_ready", bus_resp_ready, 0);
        checkOutput("midrst req_ready", req_ready, 1);
        checkOutput("midrst resp_valid", resp_valid, 0);
        checkOutput("midrst bus_req_valid", bus_req_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("sw after reset", 0, 1, 32'h8000000C, 32'hA1B2C3D4, 3'b010, 32'h0, 0, 0, 0,
                      32'h8000000C, 1, 4'hF, 32'hA1B2C3D4, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
